uart_tx: RTL

UART transmitter. It is the transmit-side counterpart of the receiver top (rx_fsm/sipo/parity_checker/stop_bit_checker).
- Accepts a parallel word through a valid/ready handshake.
- Serialises it on TX_OUT as one frame: start bit, `DATA_WIDTH data bits LSB first, parity bit, stop bit.
- Frame format matches the receiver exactly, so TX_OUT can be looped directly to RX_IN for self-test.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/piso.sv | 27 ++
 rtl/uart_tx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit types and frame constants.
// The word width comes from the global DATA_WIDTH define, which defaults to 8 when nothing else sets it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int DATA_BITS  = `DATA_WIDTH;
   localparam int FRAME_BITS = `DATA_WIDTH + 3;

   // Odd parity is the inverse of the plain XOR reduction.
   function automatic logic parity_of(input logic [`DATA_WIDTH-1:0] word, input logic odd);
      return odd ? ~^word : ^word;
   endfunction

endpackage

// File: rtl/piso.sv
// Parallel-in serial-out shift register, LSB first.
// This is the transmit-side mirror of sipo. A load takes priority over a shift.
module piso #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] load_data,
   output logic             serial_out
);

   logic [WIDTH-1:0] shift_reg;

   always_ff @(posedge clk) begin
      if (rst)
         shift_reg <= '0;
      else if (load)
         shift_reg <= load_data;
      else if (shift)
         shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
   end

   assign serial_out = shift_reg[0];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, parity bit, stop bit.
// Defining UART_TX_HOLD_BUF_EN adds a one-entry holding register so frames can follow each other back-to-back.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic                   TX_CLK,
   input  logic                   TX_RST,
   input  logic                   TX_VALID,
   input  logic [`DATA_WIDTH-1:0] TX_DATA,
   output logic                   TX_READY,
   output logic                   TX_OUT,
   output logic                   TX_BUSY
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int BW = $clog2(`DATA_WIDTH + 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(`DATA_WIDTH - 1);

   tx_state_t              state;
   logic [CW-1:0]          cyc_cnt;
   logic [BW-1:0]          bit_cnt;
   logic                   parity_bit;
   logic                   tx_out_q;
   logic                   tx_busy_q;
   logic                   accept;
   logic                   bit_end;
   logic                   load_shift;
   logic                   shift_en;
   logic [`DATA_WIDTH-1:0] load_word;
   logic                   serial_out;

`ifdef UART_TX_HOLD_BUF_EN
   logic                   hold_full;
   logic [`DATA_WIDTH-1:0] hold_data;
   logic                   load_from_hold;
   logic                   hold_store;

   assign TX_READY = !hold_full;
`else
   assign TX_READY = (state == IDLE);
`endif

   assign accept  = TX_VALID && TX_READY;
   assign bit_end = (cyc_cnt == CYC_LAST);
   assign TX_OUT  = tx_out_q;
   assign TX_BUSY = tx_busy_q;

   // The register shifts on the same edge that copies its bit 0 onto the line, so serial_out always holds the next data bit.
   always_comb begin
      load_shift = 1'b0;
      shift_en   = 1'b0;
      load_word  = TX_DATA;
`ifdef UART_TX_HOLD_BUF_EN
      load_from_hold = 1'b0;
`endif
      case (state)
         IDLE:  load_shift = accept;
         START: shift_en   = bit_end;
         DATA:  shift_en   = bit_end && (bit_cnt != BIT_LAST);
`ifdef UART_TX_HOLD_BUF_EN
         STOP: begin
            if (bit_end) begin
               if (hold_full) begin
                  load_shift     = 1'b1;
                  load_from_hold = 1'b1;
                  load_word      = hold_data;
               end else begin
                  load_shift = accept;
               end
            end
         end
`endif
         default: ;
      endcase
   end

   piso #(.WIDTH(`DATA_WIDTH)) u_piso (
      .clk        (TX_CLK),
      .rst        (TX_RST),
      .load       (load_shift),
      .shift      (shift_en),
      .load_data  (load_word),
      .serial_out (serial_out)
   );

`ifdef UART_TX_HOLD_BUF_EN
   assign hold_store = accept && !load_shift;

   // A store and a drain on the same edge leave the buffer full holding the new word.
   always_ff @(posedge TX_CLK) begin
      if (TX_RST) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else if (hold_store) begin
         hold_full <= 1'b1;
         hold_data <= TX_DATA;
      end else if (load_from_hold) begin
         hold_full <= 1'b0;
      end
   end
`endif

   always_ff @(posedge TX_CLK) begin
      if (TX_RST) begin
         state      <= IDLE;
         tx_out_q   <= 1'b1;
         tx_busy_q  <= 1'b0;
         cyc_cnt    <= '0;
         bit_cnt    <= '0;
         parity_bit <= 1'b0;
      end else begin
         if (state != IDLE)
            cyc_cnt <= bit_end ? '0 : cyc_cnt + 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= START;
                  tx_out_q   <= 1'b0;
                  tx_busy_q  <= 1'b1;
                  cyc_cnt    <= '0;
                  parity_bit <= parity_of(load_word, PARITY_ODD);
               end
            end
            START: begin
               if (bit_end) begin
                  state    <= DATA;
                  tx_out_q <= serial_out;
                  bit_cnt  <= '0;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_cnt == BIT_LAST) begin
                     state    <= PARITY;
                     tx_out_q <= parity_bit;
                  end else begin
                     bit_cnt  <= bit_cnt + 1'b1;
                     tx_out_q <= serial_out;
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state    <= STOP;
                  tx_out_q <= 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (load_shift) begin
                     state      <= START;
                     tx_out_q   <= 1'b0;
                     parity_bit <= parity_of(load_word, PARITY_ODD);
                  end else begin
                     state     <= IDLE;
                     tx_out_q  <= 1'b1;
                     tx_busy_q <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
